// File: rtl/imm_control_unit.sv
// Hardwired Moore sequencer for the immediate ALU instructions addi/andi/ori.
// Outputs are registered from the next state so each strobe is clean for its whole state.
module imm_control_unit_chk (
  input logic       clk,
  input logic       clr,
  input logic [5:0] srcs
);
  a_one_bus_source: assert property (@(posedge clk) disable iff (clr) $onehot0(srcs));
endmodule

module imm_control_unit #(
  parameter logic [4:0] OP_ADDI = 5'b01100,
  parameter logic [4:0] OP_ANDI = 5'b01101,
  parameter logic [4:0] OP_ORI  = 5'b01110,
  parameter logic [4:0] ALU_ADD = 5'd3,
  parameter logic [4:0] ALU_AND = 5'd5,
  parameter logic [4:0] ALU_OR  = 5'd6,
  parameter logic [4:0] ALU_INC = 5'd19
) (
  input  logic        clk,
  input  logic        clr,
  input  logic        run,
  input  logic        stop,
  input  logic [31:0] ir,
  output logic        PCout,
  output logic        Zlowout,
  output logic        MDRout,
  output logic        Cout,
  output logic        Rout,
  output logic        BAout,
  output logic        MARin,
  output logic        PCin,
  output logic        MDRin,
  output logic        IRin,
  output logic        RYin,
  output logic        Zhighin,
  output logic        Zlowin,
  output logic        Rin,
  output logic        Gra,
  output logic        Grb,
  output logic        Grc,
  output logic        pc_increment,
  output logic        read,
  output logic        memoryRead,
  output logic        memoryWrite,
  output logic [4:0]  alu_control,
  output logic        busy,
  output logic        instr_done,
  output logic        illegal,
  output logic [3:0]  state
);
  typedef enum logic [3:0] {
    IDLE = 4'd0, T0 = 4'd1, T1 = 4'd2, T2 = 4'd3,
    T3 = 4'd4, T4 = 4'd5, T5 = 4'd6, HALT = 4'd7
  } state_t;

  typedef struct packed {
    logic pc_out, zlow_out, mdr_out, c_out, r_out;
    logic mar_in, pc_in, mdr_in, ir_in, ry_in, zhigh_in, zlow_in, r_in;
    logic gra, grb, pc_inc, rd, mem_rd, done, bsy;
    logic [4:0] alu;
  } ctrl_t;

  state_t     st, nxt;
  logic [4:0] op_q, op_nxt;
  logic       illegal_nxt;
  ctrl_t      ctrl, ctrl_nxt;
  logic       unused_ir;

  assign unused_ir = ^ir[26:0];

  function automatic logic is_legal(input logic [4:0] op);
    return (op == OP_ADDI) || (op == OP_ANDI) || (op == OP_ORI);
  endfunction

  function automatic ctrl_t decode(input state_t s, input logic [4:0] op);
    ctrl_t c;
    c = '0;
    case (s)
      T0: begin
        c.pc_out = 1'b1; c.mar_in = 1'b1; c.pc_inc = 1'b1; c.alu = ALU_INC;
        c.zhigh_in = 1'b1; c.zlow_in = 1'b1; c.bsy = 1'b1;
      end
      T1: begin
        c.zlow_out = 1'b1; c.pc_in = 1'b1; c.rd = 1'b1; c.mem_rd = 1'b1;
        c.mdr_in = 1'b1; c.bsy = 1'b1;
      end
      T2: begin
        c.mdr_out = 1'b1; c.ir_in = 1'b1; c.bsy = 1'b1;
      end
      T3: begin
        c.grb = 1'b1; c.r_out = 1'b1; c.ry_in = 1'b1; c.bsy = 1'b1;
      end
      T4: begin
        c.c_out = 1'b1; c.zhigh_in = 1'b1; c.zlow_in = 1'b1; c.bsy = 1'b1;
        case (op)
          OP_ADDI: c.alu = ALU_ADD;
          OP_ANDI: c.alu = ALU_AND;
          OP_ORI:  c.alu = ALU_OR;
          default: c.alu = 5'd0;
        endcase
      end
      T5: begin
        c.zlow_out = 1'b1; c.gra = 1'b1; c.r_in = 1'b1; c.done = 1'b1; c.bsy = 1'b1;
      end
      default: c = '0;
    endcase
    return c;
  endfunction

  // Next state, opcode capture and illegal flag; outputs decoded from where we are going
  always_comb begin
    nxt         = IDLE;
    op_nxt      = op_q;
    illegal_nxt = illegal;
    case (st)
      IDLE: nxt = run ? T0 : IDLE;
      T0:   nxt = T1;
      T1:   nxt = T2;
      T2:   nxt = T3;
      T3: begin
        op_nxt = ir[31:27];
        if (is_legal(ir[31:27])) begin
          nxt = T4;
        end else begin
          nxt         = HALT;
          illegal_nxt = 1'b1;
        end
      end
      T4:   nxt = T5;
      T5: begin
        if (stop) begin
          nxt = HALT;
        end else if (run) begin
          nxt = T0;
        end else begin
          nxt = IDLE;
        end
      end
      HALT:    nxt = HALT;
      default: nxt = IDLE;
    endcase
    ctrl_nxt = decode(nxt, op_nxt);
  end

  // State and registered strobes
  always_ff @(posedge clk) begin
    if (clr) begin
      st      <= IDLE;
      op_q    <= 5'd0;
      illegal <= 1'b0;
      ctrl    <= '0;
    end else begin
      st      <= nxt;
      op_q    <= op_nxt;
      illegal <= illegal_nxt;
      ctrl    <= ctrl_nxt;
    end
  end

  assign state        = st;
  assign PCout        = ctrl.pc_out;
  assign Zlowout      = ctrl.zlow_out;
  assign MDRout       = ctrl.mdr_out;
  assign Cout         = ctrl.c_out;
  assign Rout         = ctrl.r_out;
  assign BAout        = 1'b0;
  assign MARin        = ctrl.mar_in;
  assign PCin         = ctrl.pc_in;
  assign MDRin        = ctrl.mdr_in;
  assign IRin         = ctrl.ir_in;
  assign RYin         = ctrl.ry_in;
  assign Zhighin      = ctrl.zhigh_in;
  assign Zlowin       = ctrl.zlow_in;
  assign Rin          = ctrl.r_in;
  assign Gra          = ctrl.gra;
  assign Grb          = ctrl.grb;
  assign Grc          = 1'b0;
  assign pc_increment = ctrl.pc_inc;
  assign read         = ctrl.rd;
  assign memoryRead   = ctrl.mem_rd;
  assign memoryWrite  = 1'b0;
  assign alu_control  = ctrl.alu;
  assign busy         = ctrl.bsy;
  assign instr_done   = ctrl.done;

  imm_control_unit_chk u_chk (
    .clk  (clk),
    .clr  (clr),
    .srcs ({PCout, Zlowout, MDRout, Cout, Rout, BAout})
  );
endmodule

// File: tb/tb_imm_control_unit.sv
// Bench for imm_control_unit: drives a small behavioural datapath from the DUT strobes
// and checks per-cycle state/strobes plus the resulting register file and PC.
module tb_imm_control_unit;
  logic clk = 1'b0, clr = 1'b1, run = 1'b0, stop = 1'b0, preload = 1'b1;
  logic PCout, Zlowout, MDRout, Cout, Rout, BAout, MARin, PCin, MDRin, IRin, RYin;
  logic Zhighin, Zlowin, Rin, Gra, Grb, Grc, pc_increment, read, memoryRead, memoryWrite;
  logic busy, instr_done, illegal;
  logic [4:0] alu_control;
  logic [3:0] state;
  int n_cmp = 0, n_bad = 0;

  // Datapath model
  logic [31:0] pc_m, mar_m, mdr_m, ir_m, y_m, z_m, bus, alu_out, cval;
  logic [31:0] rf [16];
  logic [31:0] mem [16];
  logic [3:0]  sel;
  int rin_cnt;

  always #5 clk = ~clk;

  imm_control_unit dut (
    .clk(clk), .clr(clr), .run(run), .stop(stop), .ir(ir_m),
    .PCout(PCout), .Zlowout(Zlowout), .MDRout(MDRout), .Cout(Cout), .Rout(Rout), .BAout(BAout),
    .MARin(MARin), .PCin(PCin), .MDRin(MDRin), .IRin(IRin), .RYin(RYin), .Zhighin(Zhighin),
    .Zlowin(Zlowin), .Rin(Rin), .Gra(Gra), .Grb(Grb), .Grc(Grc), .pc_increment(pc_increment),
    .read(read), .memoryRead(memoryRead), .memoryWrite(memoryWrite), .alu_control(alu_control),
    .busy(busy), .instr_done(instr_done), .illegal(illegal), .state(state)
  );

  logic [23:0] obs;
  assign obs = {PCout, Zlowout, MDRout, Cout, Rout, BAout, MARin, PCin, MDRin, IRin, RYin,
                Zhighin, Zlowin, Rin, Gra, Grb, Grc, pc_increment, read, memoryRead,
                memoryWrite, instr_done, busy, illegal};

  localparam logic [23:0] B_PCOUT = 24'd1 << 23, B_ZLOUT = 24'd1 << 22, B_MDROUT = 24'd1 << 21;
  localparam logic [23:0] B_COUT  = 24'd1 << 20, B_ROUT  = 24'd1 << 19, B_MARIN  = 24'd1 << 17;
  localparam logic [23:0] B_PCIN  = 24'd1 << 16, B_MDRIN = 24'd1 << 15, B_IRIN   = 24'd1 << 14;
  localparam logic [23:0] B_RYIN  = 24'd1 << 13, B_ZHIN  = 24'd1 << 12, B_ZLIN   = 24'd1 << 11;
  localparam logic [23:0] B_RIN   = 24'd1 << 10, B_GRA   = 24'd1 << 9,  B_GRB    = 24'd1 << 8;
  localparam logic [23:0] B_PCINC = 24'd1 << 6,  B_READ  = 24'd1 << 5,  B_MRD    = 24'd1 << 4;
  localparam logic [23:0] B_DONE  = 24'd1 << 2,  B_BUSY  = 24'd1 << 1,  B_ILL    = 24'd1;

  function automatic logic [31:0] enc(input logic [4:0] op, input logic [3:0] ra,
                                      input logic [3:0] rb, input logic [18:0] c);
    return {op, ra, rb, c};
  endfunction

  always_comb begin
    cval = {{13{ir_m[18]}}, ir_m[18:0]};
    sel  = Gra ? ir_m[26:23] : (Grb ? ir_m[22:19] : (Grc ? ir_m[18:15] : 4'd0));
    if (PCout)        bus = pc_m;
    else if (Zlowout) bus = z_m;
    else if (MDRout)  bus = mdr_m;
    else if (Cout)    bus = cval;
    else if (Rout)    bus = rf[sel];
    else              bus = 32'd0;
    if (pc_increment)             alu_out = bus + 32'd1;
    else if (alu_control == 5'd3) alu_out = y_m + bus;
    else if (alu_control == 5'd5) alu_out = y_m & bus;
    else if (alu_control == 5'd6) alu_out = y_m | bus;
    else                          alu_out = 32'd0;
  end

  always @(posedge clk) begin
    if (preload) begin
      pc_m <= 32'd0; mar_m <= 32'd0; mdr_m <= 32'd0; ir_m <= 32'd0;
      y_m <= 32'd0; z_m <= 32'd0; rin_cnt <= 0;
      for (int i = 0; i < 16; i++) rf[i] <= 32'd0;
      rf[6] <= 32'h12; rf[7] <= 32'hFF; rf[9] <= 32'h62; rf[12] <= 32'h55;
    end else begin
      if (MARin)  mar_m <= bus;
      if (PCin)   pc_m  <= bus;
      if (MDRin)  mdr_m <= read ? mem[mar_m[3:0]] : bus;
      if (IRin)   ir_m  <= bus;
      if (RYin)   y_m   <= bus;
      if (Zlowin) z_m   <= alu_out;
      if (Rin) begin
        rf[sel] <= bus;
        rin_cnt <= rin_cnt + 1;
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input int idx, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s[%0d]: got %h, expected %h", name, idx, act, exp);
    end
  endtask

  typedef struct {
    logic        run;
    logic        stop;
    logic [3:0]  st;
    logic [23:0] outs;
    logic [4:0]  alu;
  } vec_t;

  vec_t        vec [19];
  logic [23:0] exp_st [8];
  logic [4:0]  alu_k [3];
  int          rin0;

  initial begin
    exp_st[0] = 24'd0;
    exp_st[1] = B_PCOUT | B_MARIN | B_PCINC | B_ZHIN | B_ZLIN | B_BUSY;
    exp_st[2] = B_ZLOUT | B_PCIN | B_READ | B_MRD | B_MDRIN | B_BUSY;
    exp_st[3] = B_MDROUT | B_IRIN | B_BUSY;
    exp_st[4] = B_GRB | B_ROUT | B_RYIN | B_BUSY;
    exp_st[5] = B_COUT | B_ZHIN | B_ZLIN | B_BUSY;
    exp_st[6] = B_ZLOUT | B_GRA | B_RIN | B_DONE | B_BUSY;
    exp_st[7] = 24'd0;
    alu_k[0] = 5'd3; alu_k[1] = 5'd5; alu_k[2] = 5'd6;
    for (int k = 0; k < 3; k++)
      for (int s = 0; s < 6; s++)
        vec[6*k+s] = '{1'b1, 1'b0, 4'(s + 1), exp_st[s+1],
                       (s == 0) ? 5'd19 : ((s == 4) ? alu_k[k] : 5'd0)};
    vec[18] = '{1'b0, 1'b0, 4'd0, 24'd0, 5'd0};

    for (int i = 0; i < 16; i++) mem[i] = 32'd0;
    mem[0] = enc(5'b01100, 4'd5, 4'd6, 19'h7FFF9);
    mem[1] = enc(5'b01101, 4'd7, 4'd7, 19'h00095);
    mem[2] = enc(5'b01110, 4'd8, 4'd9, 19'h00095);
    mem[3] = enc(5'b01100, 4'd10, 4'd6, 19'h00001);
    mem[4] = enc(5'b11111, 4'd11, 4'd6, 19'h00000);
    mem[5] = enc(5'b01100, 4'd12, 4'd6, 19'h7FFF9);

    // Reset state, and IDLE holds without run
    tick(); tick();
    check("rst_state", 0, 32'(state), 32'd0);
    check("rst_outs", 0, 32'(obs), 32'd0);
    check("rst_alu", 0, 32'(alu_control), 32'd0);
    preload = 1'b0; clr = 1'b0;
    tick();
    check("idle_hold", 0, 32'(state), 32'd0);

    // Three back-to-back instructions, then run dropped in the last T5
    for (int i = 0; i < 19; i++) begin
      run = vec[i].run; stop = vec[i].stop;
      tick();
      check("vec_state", i, 32'(state), 32'(vec[i].st));
      check("vec_outs", i, 32'(obs), 32'(vec[i].outs));
      check("vec_alu", i, 32'(alu_control), 32'(vec[i].alu));
    end
    check("addi_r5", 0, rf[5], 32'h0B);
    check("andi_r7", 0, rf[7], 32'h95);
    check("ori_r8", 0, rf[8], 32'hF7);
    check("pc_after3", 0, pc_m, 32'd3);

    // stop raised in T2 with run still high: finish, then HALT for good
    run = 1'b1;
    tick(); tick(); tick();
    check("stop_at_t2", 0, 32'(state), 32'd3);
    stop = 1'b1;
    tick(); tick(); tick();
    check("stop_t5_outs", 0, 32'(obs), 32'(exp_st[6]));
    tick();
    check("stop_halt", 0, 32'(state), 32'd7);
    check("stop_outs", 0, 32'(obs), 32'd0);
    for (int i = 0; i < 4; i++) begin
      tick();
      check("halt_no_marin", i, {31'd0, MARin}, 32'd0);
      check("halt_state", i, 32'(state), 32'd7);
    end
    check("stop_r10", 0, rf[10], 32'h13);
    check("stop_pc", 0, pc_m, 32'd4);

    // Illegal opcode: HALT straight after T3, sticky flag, no register write
    clr = 1'b1; run = 1'b0; stop = 1'b0;
    tick();
    clr = 1'b0;
    tick();
    check("clr_from_halt", 0, 32'(state), 32'd0);
    rin0 = rin_cnt;
    run = 1'b1;
    tick(); tick(); tick(); tick();
    check("ill_t3", 0, 32'(state), 32'd4);
    tick();
    check("ill_halt", 0, 32'(state), 32'd7);
    check("ill_outs", 0, 32'(obs), 32'(B_ILL));
    tick(); tick(); tick();
    check("ill_sticky", 0, {31'd0, illegal}, 32'd1);
    check("ill_no_rin", 0, 32'(rin_cnt), 32'(rin0));
    check("ill_r11", 0, rf[11], 32'd0);

    // Reset in T4: abort, no write-back, Z frozen after the T4 load
    clr = 1'b1; run = 1'b0;
    tick();
    check("ill_cleared", 0, {31'd0, illegal}, 32'd0);
    clr = 1'b0; run = 1'b1;
    tick(); tick(); tick(); tick(); tick();
    check("mid_t4", 0, 32'(state), 32'd5);
    check("mid_t4_alu", 0, 32'(alu_control), 32'd3);
    rin0 = rin_cnt;
    clr = 1'b1;
    tick();
    check("mid_state", 0, 32'(state), 32'd0);
    check("mid_outs", 0, 32'(obs), 32'd0);
    check("mid_alu", 0, 32'(alu_control), 32'd0);
    clr = 1'b0; run = 1'b0;
    tick(); tick();
    check("mid_idle", 0, 32'(state), 32'd0);
    check("mid_z", 0, z_m, 32'h0B);
    check("mid_r12", 0, rf[12], 32'h55);
    check("mid_no_rin", 0, 32'(rin_cnt), 32'(rin0));
    check("mid_pc", 0, pc_m, 32'd6);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
